seq_divider: RTL and testbench

Sequential restoring divider with a serial-load operand bus. It is the inverse of the team's repeated-addition multiplier datapath/controller pair. Dividend and divisor arrive on a shared `data_in` bus on consecutive cycles after `start`. The block then produces quotient and remainder after a fixed WIDTH-cycle iteration and reports completion with `done`.

---
 rtl/seq_div_pkg.sv | 18 +
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_div_ctrl.sv | 75 +++++++
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LD_A,
    LD_B,
    CALC,
    DONE
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bus of seq_divider; the requester uses master, the divider uses slave.
interface seq_divider_if
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             dbz;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, dbz
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, dbz
  );

endinterface

// File: rtl/seq_div_ctrl.sv
// Controller for seq_divider: sequencing FSM, iteration counter and datapath strobes.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic divisor_zero,
  output logic accept,
  output logic ld_a,
  output logic ld_b,
  output logic ld_zero,
  output logic step,
  output logic last,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // busy and done are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LD_A;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LD_A: state <= LD_B;
        LD_B: begin
          cnt <= '0;
          if (divisor_zero) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == LAST_CNT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign accept  = ((state == IDLE) || (state == DONE)) && start;
  assign ld_a    = (state == LD_A);
  assign ld_b    = (state == LD_B);
  assign ld_zero = (state == LD_B) && divisor_zero;
  assign step    = (state == CALC);
  assign last    = (state == CALC) && (cnt == LAST_CNT);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider datapath; instantiates seq_div_ctrl.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  logic accept, ld_a, ld_b, ld_zero, step, last;
  logic divisor_zero;

  logic [WIDTH-1:0] dividend, divisor, q, r;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;
  logic [WIDTH-1:0] a_mag, b_mag, diff, q_next, r_next, quo_fix, rem_fix;
  logic [WIDTH:0]   t;
  logic             ge;

  assign divisor_zero = (bus.data_in == '0);

  seq_div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (bus.start),
    .divisor_zero (divisor_zero),
    .accept       (accept),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .ld_zero      (ld_zero),
    .step         (step),
    .last         (last),
    .busy         (bus.busy),
    .done         (bus.done)
  );

  // The partial remainder stays below the divisor, so only the trial value T needs the extra bit.
  assign t      = {r, q[WIDTH-1]};
  assign ge     = (t >= {1'b0, divisor});
  assign diff   = t[WIDTH-1:0] - divisor;
  assign r_next = ge ? diff : t[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};

`ifdef SEQ_DIV_SIGNED_EN
  logic sign_a, sign_b;

  assign a_mag   = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
  assign b_mag   = bus.data_in[WIDTH-1] ? ('0 - bus.data_in) : bus.data_in;
  assign quo_fix = (sign_a ^ sign_b) ? ('0 - q_next) : q_next;
  assign rem_fix = sign_a ? ('0 - r_next) : r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (ld_b && !ld_zero) begin
      sign_a <= dividend[WIDTH-1];
      sign_b <= bus.data_in[WIDTH-1];
    end
  end
`else
  assign a_mag   = dividend;
  assign b_mag   = bus.data_in;
  assign quo_fix = q_next;
  assign rem_fix = r_next;
`endif

  // The final shift step and the result latch share an edge, so results come from the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend    <= '0;
      divisor     <= '0;
      q           <= '0;
      r           <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      if (accept)
        dbz_q <= 1'b0;
      if (ld_a)
        dividend <= bus.data_in;
      if (ld_zero) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end else if (ld_b) begin
        divisor <= b_mag;
        q       <= a_mag;
        r       <= '0;
      end
      if (step) begin
        q <= q_next;
        r <= r_next;
      end
      if (last) begin
        quotient_q  <= quo_fix;
        remainder_q <= rem_fix;
      end
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: timeline/arithmetic model plus directed and random operations.
module tb_seq_divider;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: plain / and % on the captured operands.
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
    z = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      if (a == 16'h8000 && b == 16'hFFFF) begin
        q = 16'h8000;
        r = '0;
      end else begin
        q = W'($signed(a) / $signed(b));
        r = W'($signed(a) % $signed(b));
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Timeline model: counts edges since the accepted start and commits the arithmetic result.
  bit            m_active;
  int            m_k;
  logic [W-1:0]  m_a, m_b, m_q, m_r;
  logic          m_done, m_dbz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_q      = '0;
      m_r      = '0;
      m_done   = 1'b0;
      m_dbz    = 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_done   = 1'b0;
        m_dbz    = 1'b0;
      end
    end else begin
      m_k++;
      if (m_k == 1) m_a = bus.data_in;
      else if (m_k == 2) m_b = bus.data_in;
      if ((m_k == 2 && m_b == '0) || m_k == 2 + W) begin
        model_div(m_a, m_b, m_q, m_r, m_dbz);
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check_output("busy", bus.busy, m_active);
    check_output("done", bus.done, m_done);
    check_output("dbz", bus.dbz, m_dbz);
    check_output("quotient", bus.quotient, m_q);
    check_output("remainder", bus.remainder, m_r);
  end

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit chain);
    if (!chain) @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = W'($urandom);
    @(posedge clk);
    #1 check_output("done_clear", bus.done, 1'b0);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = a;
    @(posedge clk);
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);
  endtask

  task automatic wait_done(input int poke, output int lat);
    lat = 2;
    forever begin
      @(negedge clk);
      bus.data_in = W'($urandom);
      bus.start   = (lat == poke);
      if (bus.done || lat >= 200) break;
      @(posedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check_output("done_seen", bus.done, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q_exp, input logic [W-1:0] r_exp, input logic z_exp,
                        input int lat_exp, input bit chain, input int poke);
    int lat;
    apply_stimulus(a, b, chain);
    wait_done(poke, lat);
    check_output({name, "_q"}, bus.quotient, q_exp);
    check_output({name, "_r"}, bus.remainder, r_exp);
    check_output({name, "_dbz"}, bus.dbz, z_exp);
    check_output({name, "_lat"}, lat, lat_exp);
  endtask

  initial begin
    logic [W-1:0] a, b, q, r;
    logic         z;
    int           lat;

    bus.start   = 1'b0;
    bus.data_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_q", bus.quotient, 0);
    check_output("rst_r", bus.remainder, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_dbz", bus.dbz, 0);
    #20 rst_n = 1'b1;

    model_div(16'd17, 16'd5, q, r, z);
    check_output("model_17_5", {q, r}, {16'd3, 16'd2});
    model_div(16'd1234, 16'd0, q, r, z);
    check_output("model_dbz", {q, r, 15'd0, z}, {16'hFFFF, 16'd1234, 16'd1});

    run_op("basic", 16'd17, 16'd5, 16'd3, 16'd2, 1'b0, 18, 1'b0, 0);
    run_op("div0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 2, 1'b0, 0);
    run_op("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 18, 1'b0, 0);
    run_op("7_9", 16'd7, 16'd9, 16'd0, 16'd7, 1'b0, 18, 1'b0, 0);
    run_op("0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 18, 1'b0, 0);
    run_op("poke", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 18, 1'b0, 9);

    apply_stimulus(16'd1000, 16'd3, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_q", bus.quotient, 0);
    check_output("abort_r", bus.remainder, 0);
    check_output("abort_done", bus.done, 0);
    check_output("abort_busy", bus.busy, 0);
    check_output("abort_dbz", bus.dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("fresh", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b0, 0);

    run_op("b2b_first", 16'd20, 16'd3, 16'd6, 16'd2, 1'b0, 18, 1'b0, 0);
    apply_stimulus(16'd50, 16'd6, 1'b1);
    #1 check_output("b2b_held_q", bus.quotient, 16'd6);
    wait_done(0, lat);
    check_output("b2b_q", bus.quotient, 16'd8);
    check_output("b2b_r", bus.remainder, 16'd2);
    check_output("b2b_lat", lat, 18);

`ifdef SEQ_DIV_SIGNED_EN
    run_op("s_m17_5", 16'hFFEF, 16'd5, 16'hFFFD, 16'hFFFE, 1'b0, 18, 1'b0, 0);
    run_op("s_17_m5", 16'd17, 16'hFFFB, 16'hFFFD, 16'd2, 1'b0, 18, 1'b0, 0);
    run_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 18, 1'b0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom);
        default: b = a;
      endcase
      model_div(a, b, q, r, z);
      run_op("rand", a, b, q, r, z, (b == '0) ? 2 : 18, 1'(i % 2), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
